// File: rtl/cs_strobe_sequencer.sv
// cs_strobe_sequencer: registered front end for a 3-to-8 active-low chip-select
// decoder. Each access runs SETUP -> ACTIVE -> HOLD. A one-entry pending buffer
// lets back-to-back accesses run with no idle gap. The decoder's select outputs
// are checked against the expected one-hot-low pattern every cycle.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no access; decoder disabled, address keeps the last slot
//   ST_SETUP | address driven, decoder disabled, SETUP_CYC cycles
//   ST_ACTIVE| decoder enabled (strobe), len+1 cycles
//   ST_HOLD  | address held, decoder disabled, HOLD_CYC cycles, done on last
module cs_strobe_sequencer #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [2:0] req_slot_i,
    input  logic [7:0] req_len_i,
    output logic       a_o,
    output logic       b_o,
    output logic       c_o,
    output logic       d_o,
    output logic       e_o,
    output logic       f_o,
    input  logic [7:0] sel_n_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Phase counters are loaded with (length - 1) and terminate at zero.
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] work_slot_q, work_slot_d;
    logic [7:0] work_len_q, work_len_d;
    logic [2:0] pend_slot_q, pend_slot_d;
    logic [7:0] pend_len_q, pend_len_d;
    logic       pend_full_q, pend_full_d;

    logic       req_ready_q, req_ready_d;
    logic       d_q, d_d;
    logic       e_q, e_d;
    logic       f_q, f_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       accept;
    logic       phase_last;
    logic [7:0] cnt_dec;
    logic [7:0] sel_exp;
    logic       mismatch;

    assign accept     = req_valid_i & req_ready_q;
    assign phase_last = (cnt_q == 8'd0);
    // Saturating decrement: the counter never wraps past zero.
    assign cnt_dec    = phase_last ? cnt_q : (cnt_q - 8'd1);

    // State register: phase state, counter, working and pending request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            work_slot_q <= 3'd0;
            work_len_q  <= 8'd0;
            pend_slot_q <= 3'd0;
            pend_len_q  <= 8'd0;
            pend_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_slot_q <= work_slot_d;
            work_len_q  <= work_len_d;
            pend_slot_q <= pend_slot_d;
            pend_len_q  <= pend_len_d;
            pend_full_q <= pend_full_d;
        end
    end

    // Next-state logic: phase transitions, counter loads and request routing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_dec;
        work_slot_d = work_slot_q;
        work_len_d  = work_len_q;
        pend_slot_d = pend_slot_q;
        pend_len_d  = pend_len_q;
        pend_full_d = pend_full_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_SETUP;
                    cnt_d       = SETUP_LD;
                    work_slot_d = req_slot_i;
                    work_len_d  = req_len_i;
                end
            end
            ST_SETUP: begin
                if (accept) begin
                    pend_slot_d = req_slot_i;
                    pend_len_d  = req_len_i;
                    pend_full_d = 1'b1;
                end
                if (phase_last) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = work_len_q;
                end
            end
            ST_ACTIVE: begin
                if (accept) begin
                    pend_slot_d = req_slot_i;
                    pend_len_d  = req_len_i;
                    pend_full_d = 1'b1;
                end
                if (phase_last) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (phase_last) begin
                    // A full buffer blocks accept (ready is low), so these
                    // two branches can never both want the working register.
                    if (pend_full_q) begin
                        state_d     = ST_SETUP;
                        cnt_d       = SETUP_LD;
                        work_slot_d = pend_slot_q;
                        work_len_d  = pend_len_q;
                        pend_full_d = 1'b0;
                    end else if (accept) begin
                        state_d     = ST_SETUP;
                        cnt_d       = SETUP_LD;
                        work_slot_d = req_slot_i;
                        work_len_d  = req_len_i;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (accept) begin
                    pend_slot_d = req_slot_i;
                    pend_len_d  = req_len_i;
                    pend_full_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: registered outputs are derived from the next state so
    // they line up with the state they describe.
    always_comb begin
        req_ready_d = ~pend_full_d;
        d_d         = (state_d == ST_ACTIVE);
        e_d         = (state_d != ST_ACTIVE);
        f_d         = (state_d != ST_ACTIVE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_HOLD) && (cnt_d == 8'd0);
        err_d       = err_q | mismatch;
    end

    // Decoder monitor: compares sel_n against the pattern implied by the
    // outputs currently being driven.
    always_comb begin
        sel_exp  = 8'hFF;
        if (d_q && !e_q && !f_q) begin
            sel_exp = ~(8'h01 << work_slot_q);
        end
        mismatch = (sel_n_i != sel_exp);
    end

    // Output register with reset values: decoder disabled, not ready.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_ready_q <= 1'b0;
            d_q         <= 1'b0;
            e_q         <= 1'b1;
            f_q         <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            req_ready_q <= req_ready_d;
            d_q         <= d_d;
            e_q         <= e_d;
            f_q         <= f_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign a_o         = work_slot_q[0];
    assign b_o         = work_slot_q[1];
    assign c_o         = work_slot_q[2];
    assign d_o         = d_q;
    assign e_o         = e_q;
    assign f_o         = f_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    // The flag is raised in the same cycle a mismatch is seen and then held
    // by err_q until reset.
    assign err_o       = err_q | (mismatch & ~rst_i);

endmodule

// File: doc/cs_strobe_sequencer.md
# cs_strobe_sequencer

Registered front end for the 3-to-8 active-low chip-select decoder. Accepts slot-access requests over a valid/ready handshake and drives the decoder's address inputs (a, b, c) and enable inputs (d, e, f) through a fixed setup → active → hold sequence. It also checks the decoder's eight select outputs against the expected pattern every cycle. It sits directly upstream of the decoder, with one pending-request buffer so back-to-back accesses need no idle gap.

## Interface
- SETUP_CYC, 2, cycles address is stable with decoder disabled before the strobe (legal 1..255)
- HOLD_CYC, 1, cycles address is held with decoder disabled after the strobe (legal 1..255)
- clk  in  1  single clock, all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request can be taken; a transfer happens when req_valid & req_ready
- req_slot  in  3  target select line 0..7 (0 = g … 7 = n)
- req_len  in  8  strobe length minus one; the active phase lasts req_len+1 cycles
- a, b, c  out  1 each  decoder address: a = slot[0], b = slot[1], c = slot[2]
- d  out  1  decoder enable, active-high
- e, f  out  1 each  decoder enables, active-low; always equal to each other
- sel_n  in  8  decoder outputs {n,m,l,k,j,i,h,g}, monitored
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse in the final HOLD cycle of each access
- err  out  1  sticky select-pattern mismatch flag

## Operation
- All outputs are registered.
- Reset values: a=b=c=0, d=0, e=f=1, busy=0, done=0, err=0, req_ready=0 while rst is high.
  - req_ready becomes 1 in the first cycle after rst falls.
- States: IDLE, SETUP, ACTIVE, HOLD.
- Working register holds slot and len. The pending buffer holds one request.
- req_ready = pending buffer empty. This holds in every state.
- Where an accepted request goes:
  - IDLE: into the working register; the next state is SETUP.
  - Final HOLD cycle with the pending buffer empty: into the working register (bypass); the next state is SETUP.
  - Any other state: into the pending buffer.
- SETUP: a/b/c = working slot, d=0, e=f=1. Lasts SETUP_CYC cycles, then ACTIVE.
- ACTIVE: d=1, e=f=0, address unchanged. Lasts req_len+1 cycles (len 255 → 256 cycles), then HOLD.
- HOLD: d=0, e=f=1, address unchanged. Lasts HOLD_CYC cycles.
  - done=1 in the last HOLD cycle.
  - Exit to SETUP if the pending buffer is full (its contents move to the working register and the buffer empties), or if a bypass request was taken. Otherwise exit to IDLE.
- IDLE: d=0, e=f=1, a/b/c keep the last slot driven (no needless toggling).
- Phase counter: 8-bit, loaded on each state entry, counts down to zero, no wrap.
- Monitor, evaluated every cycle on registered outputs and same-cycle sel_n:
  - Expected value = ~(8'b1 << slot) when d & ~e & ~f, else 8'hFF.
  - Any mismatch sets err. err clears only on rst.
- rst during any state: next cycle is IDLE with reset output values. The pending buffer is dropped, no done pulse.

## Timing
- Request accepted at cycle T from IDLE:
  - SETUP covers T+1 … T+SETUP_CYC.
  - ACTIVE starts at T+SETUP_CYC+1.
  - HOLD ends, with done, at T+SETUP_CYC+len+1+HOLD_CYC.
- Back-to-back: the next SETUP begins the cycle after done. Disabled phases never overlap.
- The address changes only on entry to SETUP. It is never changed while d=1.
- req_ready falls the cycle after the pending buffer fills. It rises the cycle after the buffer drains at HOLD exit.

## Test plan
- Reset, then slot 5, len 3 at T=10 (defaults): a=1,b=0,c=1 from 11; d=1,e=f=0 cycles 13–16; HOLD 17 with done=1; IDLE 18, busy=0.
- Back-to-back: slot 2 len 0 at T, slot 7 len 1 at T+1 → req_ready=0 at T+2. Second SETUP starts T+5 with a=b=c=1, strobe at T+7–T+8, done at T+9, req_ready=1 at T+5.
- Bypass: new request held valid, accepted in the final HOLD cycle with the buffer empty → SETUP the next cycle, no IDLE cycle, pending buffer stays empty.
- len=255, SETUP_CYC=1, HOLD_CYC=1 → active phase exactly 256 cycles, no counter wrap.
- Monitor: force sel_n bit 3 low while slot 4 is active → err=1 the same cycle and it stays 1; a correct decoder gives err=0 over a 1000-request random run.
- rst asserted mid-ACTIVE with a pending request → next cycle d=0, e=f=1, busy=0, req_ready=0; after rst falls the pending request is never issued.
